noc_packetizer: RTL and testbench

NOC_PACKETIZER -- requirements
Module: noc_packetizer

---
 rtl/noc_packetizer_if.sv | 33 +++
 rtl/noc_packetizer.sv | 209 ++++++++++++++++++++
 tb/tb_noc_packetizer.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/noc_packetizer_if.sv
// Packetizer bus bundle: descriptor, payload stream, flit and credit lines.
// slave = packetizer side, master = source/router side.
interface noc_packetizer_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 2
);
  logic              pkt_valid;
  logic              pkt_ready;
  logic [ADDR_W-1:0] pkt_dest_x;
  logic [ADDR_W-1:0] pkt_dest_y;
  logic [3:0]        pkt_len;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W+1:0] flit_out;
  logic              flit_valid;
  logic              credit_in;
  logic              credit_err;

  modport slave (
    input  pkt_valid, pkt_dest_x, pkt_dest_y, pkt_len,
    input  data_valid, data_in, credit_in,
    output pkt_ready, data_ready, flit_out, flit_valid,
    output credit_err
  );

  modport master (
    output pkt_valid, pkt_dest_x, pkt_dest_y, pkt_len,
    output data_valid, data_in, credit_in,
    input  pkt_ready, data_ready, flit_out, flit_valid,
    input  credit_err
  );
endinterface

// File: rtl/noc_packetizer.sv
// NoC packetizer: descriptor + payload stream -> HEAD/BODY/TAIL flits,
// credit flow control toward the router local-port input buffer.
// Ports: clk, rst (async active-high), bus (noc_packetizer_if.slave):
//   pkt_valid/pkt_ready/pkt_dest_x/pkt_dest_y/pkt_len  descriptor
//   data_valid/data_ready/data_in                     payload stream
//   flit_out/flit_valid                               registered flits
//   credit_in/credit_err                              credit return
// Optional macro NOC_PACKETIZER_STATS_EN adds pkt_count, flit_count,
// stall_count (16-bit saturating).
module noc_packetizer #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 2,
  parameter int BUF_DEPTH = 4,
  parameter int SRC_X     = 0,
  parameter int SRC_Y     = 0,
  parameter int MAX_LEN   = 8
) (
  input  logic             clk,
  input  logic             rst,
  noc_packetizer_if.slave  bus
`ifdef NOC_PACKETIZER_STATS_EN
  ,
  output logic [15:0]      pkt_count,
  output logic [15:0]      flit_count,
  output logic [15:0]      stall_count
`endif
);

  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(BUF_DEPTH);
  localparam logic [3:0]    LEN_MAX  = 4'(MAX_LEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_PAY  = 2'd2;

  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_BODY = 2'b10;
  localparam logic [1:0] T_TAIL = 2'b11;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] dx_q, dx_d;
  logic [ADDR_W-1:0] dy_q, dy_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CW-1:0]     cred_q, cred_d;
  logic              err_q, err_d;
  logic              fv_q, fv_d;
  logic [DATA_W+1:0] fo_q, fo_d;

  logic              has_cred;
  logic              accept;
  logic              send_head;
  logic              send_pay;
  logic              send;
  logic              last;
  logic [3:0]        len_clamp;
  logic [DATA_W-1:0] head_pl;

  assign has_cred  = (cred_q != '0);
  assign accept    = bus.pkt_valid && (state_q == S_IDLE);
  assign send_head = (state_q == S_HEAD) && has_cred;
  assign send_pay  = (state_q == S_PAY) && has_cred
                   && bus.data_valid;
  assign send      = send_head || send_pay;
  assign last      = (cnt_q == len_q - 4'd1);

  assign bus.pkt_ready  = (state_q == S_IDLE);
  assign bus.data_ready = (state_q == S_PAY) && has_cred;
  assign bus.flit_out   = fo_q;
  assign bus.flit_valid = fv_q;
  assign bus.credit_err = err_q;

  always_comb begin
    len_clamp = bus.pkt_len;
    if (bus.pkt_len == 4'd0) begin
      len_clamp = 4'd1;
    end else if (bus.pkt_len > LEN_MAX) begin
      len_clamp = LEN_MAX;
    end
  end

  always_comb begin
    head_pl = '0;
    head_pl[ADDR_W-1:0]          = dx_q;
    head_pl[2*ADDR_W-1:ADDR_W]   = dy_q;
    head_pl[3*ADDR_W-1:2*ADDR_W] = ADDR_W'(SRC_X);
    head_pl[4*ADDR_W-1:3*ADDR_W] = ADDR_W'(SRC_Y);
    head_pl[4*ADDR_W+3:4*ADDR_W] = len_q;
  end

  always_comb begin
    state_d = state_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_HEAD;
          dx_d    = bus.pkt_dest_x;
          dy_d    = bus.pkt_dest_y;
          len_d   = len_clamp;
          cnt_d   = 4'd0;
        end
      end
      S_HEAD: begin
        if (send_head) state_d = S_PAY;
      end
      S_PAY: begin
        if (send_pay) begin
          cnt_d = cnt_q + 4'd1;
          if (last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fv_d = send;
    fo_d = fo_q;
    unique case (1'b1)
      send_head: fo_d = {T_HEAD, head_pl};
      send_pay:  fo_d = {last ? T_TAIL : T_BODY, bus.data_in};
      default:   fo_d = fo_q;
    endcase
  end

  // A return while the counter is full has no slot to give back;
  // flag it and keep the count. Send + return cancel out.
  always_comb begin
    cred_d = cred_q;
    err_d  = err_q;
    unique case ({send, bus.credit_in})
      2'b10: cred_d = cred_q - CW'(1);
      2'b01: begin
        if (cred_q == CRED_MAX) err_d  = 1'b1;
        else                    cred_d = cred_q + CW'(1);
      end
      default: cred_d = cred_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dx_q    <= '0;
      dy_q    <= '0;
      len_q   <= 4'd1;
      cnt_q   <= 4'd0;
      cred_q  <= CRED_MAX;
      err_q   <= 1'b0;
      fv_q    <= 1'b0;
      fo_q    <= '0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      cred_q  <= cred_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fo_q    <= fo_d;
    end
  end

`ifdef NOC_PACKETIZER_STATS_EN
  logic [15:0] pc_q, pc_d;
  logic [15:0] fc_q, fc_d;
  logic [15:0] sc_q, sc_d;
  logic        pending;

  // Something would go out this cycle if a credit were available.
  assign pending = (state_q == S_HEAD)
                || ((state_q == S_PAY) && bus.data_valid);

  always_comb begin
    pc_d = pc_q;
    fc_d = fc_q;
    sc_d = sc_q;
    if (send_pay && last && pc_q != 16'hFFFF)
      pc_d = pc_q + 16'd1;
    if (send && fc_q != 16'hFFFF)
      fc_d = fc_q + 16'd1;
    if (pending && !has_cred && sc_q != 16'hFFFF)
      sc_d = sc_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= '0;
      fc_q <= '0;
      sc_q <= '0;
    end else begin
      pc_q <= pc_d;
      fc_q <= fc_d;
      sc_q <= sc_d;
    end
  end

  assign pkt_count   = pc_q;
  assign flit_count  = fc_q;
  assign stall_count = sc_q;
`endif

endmodule

// File: tb/tb_noc_packetizer.sv
// Bench for noc_packetizer: expected flit stream built from descriptors,
// per-cycle flit compare, directed credit/reset scenarios.
module tb_noc_packetizer;

  localparam int SRC_X = 0;
  localparam int SRC_Y = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  noc_packetizer_if #(.DATA_W(32), .ADDR_W(2)) bus ();

`ifdef NOC_PACKETIZER_STATS_EN
  logic [15:0] pkt_count, flit_count, stall_count;
`endif

  noc_packetizer #(
    .DATA_W(32), .ADDR_W(2), .BUF_DEPTH(4),
    .SRC_X(SRC_X), .SRC_Y(SRC_Y), .MAX_LEN(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef NOC_PACKETIZER_STATS_EN
    ,
    .pkt_count(pkt_count),
    .flit_count(flit_count),
    .stall_count(stall_count)
`endif
  );

  int ncmp = 0;
  int nerr = 0;

  logic [33:0] exp_mem [1024];
  int          wr = 0;
  int          rd = 0;
  logic [33:0] flit_mem [1024];
  int          stamp_mem [1024];
  int          flits_seen = 0;
  int          cyc = 0;
  int          given = 0;
  bit          feed_busy = 0;
  bit          abort = 0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic int clamp(int len);
    if (len == 0) return 1;
    if (len > 8) return 8;
    return len;
  endfunction

  function automatic logic [33:0] head_word(int dx, int dy, int len);
    int v;
    v = dx + (dy << 2) + (SRC_X << 4) + (SRC_Y << 6)
      + (clamp(len) << 8);
    return {2'b01, 32'(v)};
  endfunction

  task automatic expect_pkt(int dx, int dy, int len, int base);
    int n;
    logic [33:0] w;
    n = clamp(len);
    exp_mem[wr % 1024] = head_word(dx, dy, len);
    wr++;
    for (int i = 0; i < n; i++) begin
      w = {2'b10, 32'(base + i)};
      if (i == n - 1) w[33:32] = 2'b11;
      exp_mem[wr % 1024] = w;
      wr++;
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        rd = wr;
      end else if (bus.flit_valid) begin
        flit_mem[flits_seen % 1024]  = bus.flit_out;
        stamp_mem[flits_seen % 1024] = cyc;
        flits_seen++;
        if (rd == wr) begin
          ncmp++;
          nerr++;
          $display("FAIL flit_unexpected got=%0h want=none",
                   bus.flit_out);
        end else begin
          chk("flit", 64'(bus.flit_out), 64'(exp_mem[rd % 1024]));
          rd++;
        end
      end
    end
  endtask

  task automatic feed(int dx, int dy, int len, int base);
    int n, i, t;
    bit rdy;
    n = clamp(len);
    bus.pkt_dest_x = 2'(dx);
    bus.pkt_dest_y = 2'(dy);
    bus.pkt_len    = 4'(len);
    bus.pkt_valid  = 1'b1;
    t = 0;
    while (!bus.pkt_ready && t < 50 && !abort) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    bus.pkt_valid  = 1'b0;
    bus.data_valid = 1'b1;
    bus.data_in    = 32'(base);
    i = 0;
    t = 0;
    while (i < n && t < 600 && !abort) begin
      rdy = bus.data_ready;
      @(negedge clk);
      t++;
      if (rdy) begin
        i++;
        bus.data_in = 32'(base + i);
      end
    end
    bus.data_valid = 1'b0;
    if (!abort) chk("feed_done", 64'(i), 64'(n));
    feed_busy = 0;
  endtask

  task automatic start_pkt(int dx, int dy, int len, int base);
    expect_pkt(dx, dy, len, base);
    feed_busy = 1;
    fork
      begin
        automatic int a = dx;
        automatic int b = dy;
        automatic int c = len;
        automatic int d = base;
        feed(a, b, c, d);
      end
    join_none
  endtask

  // Returns one credit per flit seen, never more than were consumed.
  task automatic drain(string name);
    int t = 0;
    while ((rd != wr || feed_busy || flits_seen > given) && t < 800) begin
      @(negedge clk);
      t++;
      if (!bus.credit_in && flits_seen > given) begin
        bus.credit_in = 1'b1;
        given++;
      end else begin
        bus.credit_in = 1'b0;
      end
    end
    @(negedge clk);
    bus.credit_in = 1'b0;
    if (t >= 800) chk({name, "_timeout"}, 64'(t), 64'(0));
  endtask

  task automatic wait_flits(int n, string name);
    int cnt = 0;
    int t = 0;
    while (cnt < n && t < 100) begin
      @(negedge clk);
      t++;
      if (bus.flit_valid) cnt++;
    end
    if (cnt < n) chk({name, "_timeout"}, 64'(cnt), 64'(n));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    bus.credit_in = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    given = flits_seen;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    bus.pkt_valid  = 1'b0;
    bus.pkt_dest_x = '0;
    bus.pkt_dest_y = '0;
    bus.pkt_len    = '0;
    bus.data_valid = 1'b0;
    bus.data_in    = '0;
    bus.credit_in  = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_flit_valid", 64'(bus.flit_valid), 64'(0));
    chk("rst_flit_out", 64'(bus.flit_out), 64'(0));
    chk("rst_pkt_ready", 64'(bus.pkt_ready), 64'(1));
    chk("rst_data_ready", 64'(bus.data_ready), 64'(0));
    chk("rst_credit_err", 64'(bus.credit_err), 64'(0));

    // dest (2,1), len 3, A/B/C back to back
    k = flits_seen;
    start_pkt(2, 1, 3, 32'hA);
    drain("len3");
    chk("len3_count", 64'(flits_seen - k), 64'(4));
    chk("len3_head_lit", 64'(flit_mem[k]), 64'h100000306);
    chk("len3_tail_lit", 64'(flit_mem[k + 3]), 64'h30000000C);
    chk("len3_back2back",
        64'(stamp_mem[k + 3] - stamp_mem[k]), 64'(3));

    // len 1: HEAD then TAIL, ready again afterwards
    k = flits_seen;
    start_pkt(0, 3, 1, 32'h55);
    wait_flits(2, "len1");
    @(negedge clk);
    chk("len1_ready_after", 64'(bus.pkt_ready), 64'(1));
    drain("len1");
    chk("len1_count", 64'(flits_seen - k), 64'(2));
    chk("len1_tail_lit", 64'(flit_mem[k + 1]), 64'h300000055);

    // len 0 behaves as 1, len 12 behaves as 8
    k = flits_seen;
    start_pkt(3, 0, 0, 32'h70);
    drain("len0");
    chk("len0_count", 64'(flits_seen - k), 64'(2));
    k = flits_seen;
    start_pkt(1, 3, 12, 32'h80);
    drain("len12");
    chk("len12_count", 64'(flits_seen - k), 64'(9));
    chk("len12_head_lit", 64'(flit_mem[k]), 64'h10000080D);

    // no credit returns: 4 flits then stall; one credit -> one flit
    do_reset();
    k = flits_seen;
    start_pkt(0, 0, 6, 32'h100);
    repeat (20) @(negedge clk);
    chk("stall_count4", 64'(flits_seen - k), 64'(4));
    chk("stall_fv", 64'(bus.flit_valid), 64'(0));
    chk("stall_dr", 64'(bus.data_ready), 64'(0));
    bus.credit_in = 1'b1;
    given++;
    @(negedge clk);
    bus.credit_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("one_more_flit", 64'(flits_seen - k), 64'(5));
    drain("stall");

    // credit return on the same edge as the send at credits==1
    k = flits_seen;
    start_pkt(0, 1, 6, 32'h200);
    wait_flits(3, "samecyc");
    bus.credit_in = 1'b1;
    given++;
    @(negedge clk);
    bus.credit_in = 1'b0;
    repeat (15) @(negedge clk);
    chk("samecyc_count", 64'(flits_seen - k), 64'(5));
    drain("samecyc");

    // overflow at full credits: sticky flag, count unchanged
    bus.credit_in = 1'b1;
    @(negedge clk);
    bus.credit_in = 1'b0;
    chk("overflow_err", 64'(bus.credit_err), 64'(1));
    repeat (3) @(negedge clk);
    chk("overflow_sticky", 64'(bus.credit_err), 64'(1));
    k = flits_seen;
    start_pkt(2, 2, 6, 32'h300);
    repeat (20) @(negedge clk);
    chk("overflow_cred4", 64'(flits_seen - k), 64'(4));
    drain("overflow");
    chk("overflow_sticky2", 64'(bus.credit_err), 64'(1));

    // reset mid-body of a len 5 packet
    do_reset();
    chk("rst_clears_err", 64'(bus.credit_err), 64'(0));
    start_pkt(3, 2, 5, 32'h400);
    wait_flits(2, "midrst");
    #2 rst = 1'b1;
    abort = 1;
    #1;
    chk("midrst_fv", 64'(bus.flit_valid), 64'(0));
    chk("midrst_pkt_ready", 64'(bus.pkt_ready), 64'(1));
    chk("midrst_data_ready", 64'(bus.data_ready), 64'(0));
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    abort = 0;
    given = flits_seen;
    chk("midrst_feed_stopped", 64'(feed_busy), 64'(0));
    k = flits_seen;
    start_pkt(1, 0, 3, 32'h500);
    repeat (12) @(negedge clk);
    chk("midrst_cred4", 64'(flits_seen - k), 64'(4));
    drain("midrst_a");
    k = flits_seen;
    start_pkt(2, 3, 2, 32'h600);
    drain("midrst_b");
    chk("midrst_len2_count", 64'(flits_seen - k), 64'(3));
    chk("midrst_len2_tail", 64'(flit_mem[k + 2]), 64'h300000601);

`ifdef NOC_PACKETIZER_STATS_EN
    do_reset();
    start_pkt(1, 1, 2, 32'h700);
    drain("stats_a");
    start_pkt(2, 1, 3, 32'h800);
    drain("stats_b");
    chk("stats_pkt_count", 64'(pkt_count), 64'(2));
    chk("stats_flit_count", 64'(flit_count), 64'(7));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
